// File: rtl/booth_mul8_seq_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold the value WIDTH itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

endpackage

// File: rtl/booth_mul8_seq_if.sv
// Operand/result handshake bundle between the operand bank, the multiplier core and the result consumer.
interface booth_mul8_seq_if
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic                        start;
  logic signed [WIDTH-1:0]     multiplicand;
  logic signed [WIDTH-1:0]     multiplier;
  logic                        ready;
  logic                        busy;
  logic                        done;
  logic signed [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output ready, busy, done, product
  );

endinterface

// File: rtl/booth_mul8_seq_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then arithmetic right shift of {A, Qr, q_1}.
module booth_step
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0]   a,
  input  logic signed [WIDTH-1:0] m,
  input  logic        [WIDTH-1:0] qr,
  input  logic                    q_1,
  output logic signed [WIDTH:0]   a_nx,
  output logic        [WIDTH-1:0] qr_nx,
  output logic                    q_1_nx
);

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;

  always_comb begin
    m_ext = {m[WIDTH-1], m};
    sum   = a;
    case ({qr[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    // Sign of the WIDTH+1 bit accumulator is replicated into the vacated MSB.
    a_nx   = sum >>> 1;
    qr_nx  = {sum[0], qr[WIDTH-1:1]};
    q_1_nx = qr[0];
  end

endmodule

// File: rtl/booth_mul8_seq.sv
// Sequential radix-2 Booth multiplier: one step per clock, start/ready/done handshake, product held until the next result.
module booth_mul8_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  booth_mul8_seq_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t                    state;
  state_t                    state_nx;
  logic                      accept;
  logic                      last_step;

  logic signed [WIDTH-1:0]   m;
  logic signed [WIDTH:0]     a;
  logic        [WIDTH-1:0]   qr;
  logic                      q_1;
  logic        [CW-1:0]      cnt;
  logic signed [2*WIDTH-1:0] product;

  logic signed [WIDTH:0]     a_nx;
  logic        [WIDTH-1:0]   qr_nx;
  logic                      q_1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .m      (m),
    .qr     (qr),
    .q_1    (q_1),
    .a_nx   (a_nx),
    .qr_nx  (qr_nx),
    .q_1_nx (q_1_nx)
  );

  assign last_step = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN:     if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decode purely from the state register.
  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m       <= '0;
      a       <= '0;
      qr      <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      m   <= bus.multiplicand;
      a   <= '0;
      qr  <= bus.multiplier;
      q_1 <= 1'b0;
      cnt <= CW'(WIDTH);
    end else if (state == RUN) begin
      a   <= a_nx;
      qr  <= qr_nx;
      q_1 <= q_1_nx;
      cnt <= cnt - CW'(1);
      // Result lands together with the final step, on the RUN->DONE edge.
      if (last_step) product <= $signed({a_nx[WIDTH-1:0], qr_nx});
    end
  end

endmodule
